univ_shift_reg: RTL and testbench



---
 rtl/univ_shift_reg_pkg.sv | 17 +
 rtl/univ_shift_reg_usr_cell.sv | 43 ++++
 rtl/univ_shift_reg.sv | 105 ++++++++++
 tb/tb_univ_shift_reg.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/univ_shift_reg_pkg.sv
// Shared types and helpers for the universal shift register.
// Mode encoding and the shift-counter width function live here.
package univ_shift_reg_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  // Counter width; never below one bit so the port always exists.
  function automatic int cw_f(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/univ_shift_reg_usr_cell.sv
// One bit slice of the universal shift register: a 4:1 next-state mux
// feeding an async-reset flop with its own reset value.
module usr_cell
  import univ_shift_reg_pkg::*;
#(
  parameter logic RESET_BIT = 1'b0
) (
  input  logic  clk,
  input  logic  rst,
  input  mode_e mode,
  input  logic  shr_in,
  input  logic  shl_in,
  input  logic  pd_in,
  output logic  d,
  output logic  q
);

  logic q_reg;
  logic q_next;

  always_comb begin
    q_next = q_reg;
    unique case (mode)
      MODE_HOLD: q_next = q_reg;
      MODE_SHR:  q_next = shr_in;
      MODE_SHL:  q_next = shl_in;
      MODE_LOAD: q_next = pd_in;
      default:   q_next = q_reg;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_reg <= RESET_BIT;
    end else begin
      q_reg <= q_next;
    end
  end

  assign d = q_next;
  assign q = q_reg;

endmodule

// File: rtl/univ_shift_reg.sv
// Parametrised universal shift register with shift counter and word_done pulse.
// Define UNIV_SHIFT_REG_QBAR_EN to add a registered complement output q_bar.
module univ_shift_reg
  import univ_shift_reg_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              CW        = cw_f(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic [WIDTH-1:0] pdin,
  output logic [WIDTH-1:0] q,
  output logic             sout_r,
  output logic             sout_l,
  output logic [CW-1:0]    shift_cnt,
  output logic             word_done
`ifdef UNIV_SHIFT_REG_QBAR_EN
  ,
  output logic [WIDTH-1:0] q_bar
`endif
);

  mode_e            mode_sel;
  logic [WIDTH-1:0] shr_vec;
  logic [WIDTH-1:0] shl_vec;
  logic [WIDTH-1:0] q_next;
  logic [CW-1:0]    shift_cnt_reg;
  logic [CW-1:0]    shift_cnt_next;
  logic             word_done_reg;
  logic             word_done_next;

  assign mode_sel = mode_e'(mode);
  assign shr_vec  = {sin_r, q[WIDTH-1:1]};
  assign shl_vec  = {q[WIDTH-2:0], sin_l};

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_cell
      usr_cell #(
        .RESET_BIT(RESET_VAL[gi])
      ) u_cell (
        .clk   (clk),
        .rst   (rst),
        .mode  (mode_sel),
        .shr_in(shr_vec[gi]),
        .shl_in(shl_vec[gi]),
        .pd_in (pdin[gi]),
        .d     (q_next[gi]),
        .q     (q[gi])
      );
    end
  endgenerate

  // Either shift direction advances the same counter.
  always_comb begin
    shift_cnt_next = shift_cnt_reg;
    word_done_next = 1'b0;
    unique case (mode_sel)
      MODE_SHR, MODE_SHL: begin
        if (shift_cnt_reg == CW'(WIDTH - 1)) begin
          shift_cnt_next = '0;
          word_done_next = 1'b1;
        end else begin
          shift_cnt_next = shift_cnt_reg + 1'b1;
        end
      end
      MODE_LOAD: shift_cnt_next = '0;
      default:   shift_cnt_next = shift_cnt_reg;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_cnt_reg <= '0;
      word_done_reg <= 1'b0;
    end else begin
      shift_cnt_reg <= shift_cnt_next;
      word_done_reg <= word_done_next;
    end
  end

`ifdef UNIV_SHIFT_REG_QBAR_EN
  logic [WIDTH-1:0] q_bar_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_bar_reg <= ~RESET_VAL;
    end else begin
      q_bar_reg <= ~q_next;
    end
  end

  assign q_bar = q_bar_reg;
`endif

  assign sout_r    = q[0];
  assign sout_l    = q[WIDTH-1];
  assign shift_cnt = shift_cnt_reg;
  assign word_done = word_done_reg;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg: directed vector table, async reset
// sequences and a randomized run against a word-level reference model.
module tb_univ_shift_reg;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [1:0]   mode = 2'b00;
  logic         sin_r = 1'b0;
  logic         sin_l = 1'b0;
  logic [W-1:0] pdin = '0;

  logic [W-1:0] q_a, q_b;
  logic         sout_r_a, sout_l_a, sout_r_b, sout_l_b;
  logic [1:0]   cnt_a, cnt_b;
  logic         done_a, done_b;
`ifdef UNIV_SHIFT_REG_QBAR_EN
  logic [W-1:0] qbar_a, qbar_b;
`endif

  int total = 0;
  int bad = 0;

  // Reference model: one word per DUT, shifts counted since last load/reset.
  int unsigned m_q [2];
  int          m_shifts;
  logic        m_done;

  always #5 clk = ~clk;

  univ_shift_reg #(.WIDTH(W), .RESET_VAL(4'b0000)) dut_a (
    .clk(clk), .rst(rst), .mode(mode), .sin_r(sin_r), .sin_l(sin_l), .pdin(pdin),
    .q(q_a), .sout_r(sout_r_a), .sout_l(sout_l_a), .shift_cnt(cnt_a), .word_done(done_a)
`ifdef UNIV_SHIFT_REG_QBAR_EN
    , .q_bar(qbar_a)
`endif
  );

  univ_shift_reg #(.WIDTH(W), .RESET_VAL(4'b0101)) dut_b (
    .clk(clk), .rst(rst), .mode(mode), .sin_r(sin_r), .sin_l(sin_l), .pdin(pdin),
    .q(q_b), .sout_r(sout_r_b), .sout_l(sout_l_b), .shift_cnt(cnt_b), .word_done(done_b)
`ifdef UNIV_SHIFT_REG_QBAR_EN
    , .q_bar(qbar_b)
`endif
  );

  typedef struct {
    logic [1:0]   mode;
    logic         sr;
    logic         sl;
    logic [W-1:0] pd;
    logic [W-1:0] eq;
    int           ecnt;
    logic         edone;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [1:0] m, input logic sr, input logic sl,
                     input logic [W-1:0] pd, input logic [W-1:0] eq,
                     input int ecnt, input logic edone);
    vec_t v;
    v.mode = m; v.sr = sr; v.sl = sl; v.pd = pd;
    v.eq = eq; v.ecnt = ecnt; v.edone = edone;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q[0] = 0;
    m_q[1] = 5;
    m_shifts = 0;
    m_done = 1'b0;
  endtask

  task automatic model_step(input logic [1:0] m, input logic sr, input logic sl,
                            input logic [W-1:0] pd);
    for (int k = 0; k < 2; k++) begin
      case (m)
        2'b01: m_q[k] = (m_q[k] >> 1) + (sr ? (1 << (W - 1)) : 0);
        2'b10: m_q[k] = ((m_q[k] * 2) % (1 << W)) + (sl ? 1 : 0);
        2'b11: m_q[k] = pd;
        default: ;
      endcase
    end
    if (m == 2'b11) begin
      m_shifts = 0;
      m_done = 1'b0;
    end else if (m == 2'b01 || m == 2'b10) begin
      m_shifts++;
      m_done = (m_shifts % W) == 0;
    end else begin
      m_done = 1'b0;
    end
  endtask

  task automatic step(input logic [1:0] m, input logic sr, input logic sl,
                      input logic [W-1:0] pd);
    mode = m; sin_r = sr; sin_l = sl; pdin = pd;
    @(posedge clk);
    model_step(m, sr, sl, pd);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".q_a"}, 64'(q_a), 64'(m_q[0]));
    check({tag, ".q_b"}, 64'(q_b), 64'(m_q[1]));
    check({tag, ".sout_r"}, 64'(sout_r_a), 64'(m_q[0] & 1));
    check({tag, ".sout_l"}, 64'(sout_l_a), 64'((m_q[0] >> (W - 1)) & 1));
    check({tag, ".cnt"}, 64'(cnt_a), 64'(m_shifts % W));
    check({tag, ".cnt_b"}, 64'(cnt_b), 64'(m_shifts % W));
    check({tag, ".done"}, 64'(done_a), 64'(m_done));
`ifdef UNIV_SHIFT_REG_QBAR_EN
    check({tag, ".qbar"}, 64'(qbar_a), 64'((~m_q[0]) & 32'hF));
`endif
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset values, then three hold cycles.
    check("rst.q_a", 64'(q_a), 64'h0);
    check("rst.q_b", 64'(q_b), 64'h5);
    check("rst.cnt", 64'(cnt_a), 64'h0);
    check("rst.done", 64'(done_a), 64'h0);
`ifdef UNIV_SHIFT_REG_QBAR_EN
    check("rst.qbar_b", 64'(qbar_b), 64'hA);
`endif
    for (int i = 0; i < 3; i++) begin
      step(2'b00, 1'b1, 1'b1, 4'hF);
      check_model($sformatf("hold%0d", i));
    end

    // Directed table.
    add(2'b11, 0, 0, 4'b1011, 4'b1011, 0, 0);
    add(2'b01, 0, 0, 4'h0,    4'b0101, 1, 0);
    add(2'b01, 0, 0, 4'h0,    4'b0010, 2, 0);
    add(2'b01, 0, 0, 4'h0,    4'b0001, 3, 0);
    add(2'b01, 0, 0, 4'h0,    4'b0000, 0, 1);
    add(2'b00, 0, 0, 4'h0,    4'b0000, 0, 0);
    add(2'b10, 0, 1, 4'h0,    4'b0001, 1, 0);
    add(2'b10, 0, 0, 4'h0,    4'b0010, 2, 0);
    add(2'b10, 0, 1, 4'h0,    4'b0101, 3, 0);
    add(2'b10, 0, 1, 4'h0,    4'b1011, 0, 1);
    add(2'b00, 0, 0, 4'h0,    4'b1011, 0, 0);
    add(2'b01, 0, 0, 4'h0,    4'b0101, 1, 0);
    add(2'b01, 0, 0, 4'h0,    4'b0010, 2, 0);
    add(2'b11, 0, 0, 4'b0110, 4'b0110, 0, 0);
    add(2'b01, 1, 0, 4'h0,    4'b1011, 1, 0);
    add(2'b11, 0, 0, 4'b0000, 4'b0000, 0, 0);
    add(2'b01, 1, 0, 4'h0,    4'b1000, 1, 0);
    add(2'b10, 0, 1, 4'h0,    4'b0001, 2, 0);
    add(2'b01, 0, 0, 4'h0,    4'b0000, 3, 0);
    add(2'b10, 0, 1, 4'h0,    4'b0001, 0, 1);
    add(2'b00, 0, 0, 4'h0,    4'b0001, 0, 0);
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].mode, vecs[i].sr, vecs[i].sl, vecs[i].pd);
      check($sformatf("vec%0d.q", i), 64'(q_a), 64'(vecs[i].eq));
      check($sformatf("vec%0d.sout_r", i), 64'(sout_r_a), 64'(vecs[i].eq[0]));
      check($sformatf("vec%0d.sout_l", i), 64'(sout_l_a), 64'(vecs[i].eq[W-1]));
      check($sformatf("vec%0d.cnt", i), 64'(cnt_a), 64'(vecs[i].ecnt));
      check($sformatf("vec%0d.done", i), 64'(done_a), 64'(vecs[i].edone));
    end

    // Async reset mid-word: load 1010, two shifts, rst between edges.
    step(2'b11, 0, 0, 4'b1010);
    step(2'b01, 1, 0, 4'h0);
    step(2'b10, 0, 1, 4'h0);
    check_model("pre_rst");
    #2 rst = 1'b1;
    #1;
    check("arst.q_a", 64'(q_a), 64'h0);
    check("arst.q_b", 64'(q_b), 64'h5);
    check("arst.cnt", 64'(cnt_a), 64'h0);
    check("arst.done", 64'(done_a), 64'h0);
`ifdef UNIV_SHIFT_REG_QBAR_EN
    check("arst.qbar_b", 64'(qbar_b), 64'hA);
`endif
    model_reset();
    @(negedge clk) rst = 1'b0;
    step(2'b01, 1, 0, 4'h0);
    check_model("post_rst");

    // Async reset while word_done is high.
    step(2'b11, 0, 0, 4'b1010);
    for (int i = 0; i < W; i++) step(2'b10, 1'b1, 1'b0, 4'h0);
    check("wd_before.done", 64'(done_a), 64'h1);
    #2 rst = 1'b1;
    #1;
    check("wd_rst.done", 64'(done_a), 64'h0);
    check("wd_rst.q_b", 64'(q_b), 64'h5);
    model_reset();
    @(negedge clk) rst = 1'b0;

    // Randomized run against the model.
    for (int i = 0; i < 400; i++) begin
      step(2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 4'($urandom));
      check_model($sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
